// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared types and encodings for the multi-cycle control unit
package mcu_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BRANCH, C_JUMP
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b011;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mcu_if.sv
// rtl/mcu_if.sv - control unit to datapath/IR/memory signal bundle
interface mcu_if #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
);
    logic [5:0]       op_code;
    logic [5:0]       func_code;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic             shift_src;
    logic             zero_extend;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [SEL_W-1:0] alu_sel;
    logic             instr_done;
    logic             illegal_op;
    logic             bus_error;
    logic [CNT_W-1:0] retire_count;

    modport master (
        input  op_code, func_code, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, shift_src, zero_extend,
               alu_src_b, pc_source, alu_sel, instr_done, illegal_op, bus_error,
               retire_count
    );

    modport slave (
        output op_code, func_code, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, shift_src, zero_extend,
               alu_src_b, pc_source, alu_sel, instr_done, illegal_op, bus_error,
               retire_count
    );
endinterface

// File: rtl/mcu_decode.sv
// rtl/mcu_decode.sv - combinational instruction class and ALU operation decoder
module mcu_decode
    import mcu_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [5:0]       op_code,
    input  logic [5:0]       func_code,
    output class_t           cls,
    output logic [SEL_W-1:0] alu_sel,
    output logic             shift_src,
    output logic             zero_extend,
    output logic             illegal
);
    logic [2:0] alu3;

    // Classify the instruction; func_code only matters for R-type
    always_comb begin
        cls         = C_JUMP;
        alu3        = ALU_ADD;
        shift_src   = 1'b0;
        zero_extend = 1'b0;
        illegal     = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                cls = C_RTYPE;
                case (func_code)
                    FN_ADD:  alu3 = ALU_ADD;
                    FN_SUB:  alu3 = ALU_SUB;
                    FN_AND:  alu3 = ALU_AND;
                    FN_OR:   alu3 = ALU_OR;
                    FN_SLT:  alu3 = ALU_SLT;
                    FN_SLL: begin
                        alu3      = ALU_SLL;
                        shift_src = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_J:    cls = C_JUMP;
            OP_BEQ: begin
                cls  = C_BRANCH;
                alu3 = ALU_SUB;
            end
            OP_ADDI: cls = C_ITYPE;
            OP_SLTI: begin
                cls  = C_ITYPE;
                alu3 = ALU_SLT;
            end
            OP_ANDI: begin
                cls         = C_ITYPE;
                alu3        = ALU_AND;
                zero_extend = 1'b1;
            end
            OP_ORI: begin
                cls         = C_ITYPE;
                alu3        = ALU_OR;
                zero_extend = 1'b1;
            end
            OP_LW:   cls = C_LOAD;
            OP_SW:   cls = C_STORE;
            default: illegal = 1'b1;
        endcase
    end

    assign alu_sel = SEL_W'(alu3);
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory wait and retire count
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mcu_if.master     bus
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t           state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] retire_q;
    class_t           cls_q;
    logic [SEL_W-1:0] alu_q;
    logic             shift_q;
    logic             zext_q;

    class_t           dec_cls;
    logic [SEL_W-1:0] dec_alu;
    logic             dec_shift;
    logic             dec_zext;
    logic             dec_illegal;

    logic wait_st;
    logic timeout;
    logic retire;

    mcu_decode #(.SEL_W(SEL_W)) u_decode (
        .op_code     (bus.op_code),
        .func_code   (bus.func_code),
        .cls         (dec_cls),
        .alu_sel     (dec_alu),
        .shift_src   (dec_shift),
        .zero_extend (dec_zext),
        .illegal     (dec_illegal)
    );

    assign wait_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout = wait_st && !bus.mem_ready && (wait_cnt == WAIT_W'(WAIT_MAX));
    assign retire  = (state == S_WB_MEM) || (state == S_WB_ALU) || (state == S_BRANCH) ||
                     (state == S_JUMP) || ((state == S_MEM_WR) && bus.mem_ready);

    // Sequencer: state, wait counter (zero whenever a wait state is entered), retire counter, decode latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            retire_q <= '0;
            cls_q    <= C_RTYPE;
            alu_q    <= '0;
            shift_q  <= 1'b0;
            zext_q   <= 1'b0;
        end else begin
            wait_cnt <= '0;
            if (retire) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (wait_st && !bus.mem_ready && !timeout) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready)  state <= S_DECODE;
                    else if (timeout)   state <= S_FETCH;
                end
                S_DECODE: begin
                    cls_q   <= dec_cls;
                    alu_q   <= dec_alu;
                    shift_q <= dec_shift;
                    zext_q  <= dec_zext;
                    if (dec_illegal) begin
                        state <= S_FETCH;
                    end else begin
                        case (dec_cls)
                            C_RTYPE:          state <= S_EXEC_R;
                            C_ITYPE:          state <= S_EXEC_I;
                            C_LOAD, C_STORE:  state <= S_ADDR;
                            C_BRANCH:         state <= S_BRANCH;
                            default:          state <= S_JUMP;
                        endcase
                    end
                end
                S_EXEC_R: state <= S_WB_ALU;
                S_EXEC_I: state <= S_WB_ALU;
                S_ADDR:   state <= (cls_q == C_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (bus.mem_ready)  state <= S_WB_MEM;
                    else if (timeout)   state <= S_FETCH;
                end
                S_MEM_WR: begin
                    if (bus.mem_ready || timeout) state <= S_FETCH;
                end
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Moore datapath controls from state; FETCH strobes and pulses also qualified by mem_ready
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ir_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.shift_src     = 1'b0;
        bus.zero_extend   = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.pc_source     = PCSRC_ALU;
        bus.alu_sel       = '0;
        bus.illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.alu_sel   = SEL_W'(ALU_ADD);
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b  = SRCB_IMM_SH;
                bus.alu_sel    = SEL_W'(ALU_ADD);
                bus.illegal_op = dec_illegal;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_sel   = alu_q;
                bus.shift_src = shift_q;
            end
            S_EXEC_I: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_sel     = alu_q;
                bus.zero_extend = zext_q;
            end
            S_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_sel   = SEL_W'(ALU_ADD);
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_WB_ALU: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (cls_q == C_RTYPE);
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_sel       = SEL_W'(ALU_SUB);
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.instr_done   = retire;
    assign bus.bus_error    = timeout;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized instruction-level bench for multicycle_control_unit
module tb_multicycle_control_unit;
    localparam int WAIT_MAX = 15;
    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000;
    localparam logic [2:0] A_OR = 3'b001, A_SLT = 3'b111, A_SLL = 3'b011;

    typedef enum int {K_ILL, K_R, K_I, K_LW, K_SW, K_BEQ, K_J} kind_t;

    typedef struct packed {
        logic pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
        logic mem_to_reg, reg_dst, reg_write, alu_src_a, shift_src, zero_extend;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_sel;
        logic instr_done, illegal_op, bus_error;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcu_if #(.SEL_W(3), .CNT_W(16)) bus_a ();
    mcu_if #(.SEL_W(3), .CNT_W(2))  bus_b ();

    assign bus_b.op_code   = bus_a.op_code;
    assign bus_b.func_code = bus_a.func_code;
    assign bus_b.mem_ready = bus_a.mem_ready;

    multicycle_control_unit #(.SEL_W(3), .WAIT_MAX(WAIT_MAX), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
    multicycle_control_unit #(.SEL_W(3), .WAIT_MAX(WAIT_MAX), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

    outs_t act_a, act_b;
    assign act_a = {bus_a.pc_write, bus_a.pc_write_cond, bus_a.ir_write, bus_a.i_or_d,
                    bus_a.mem_read, bus_a.mem_write, bus_a.mem_to_reg, bus_a.reg_dst,
                    bus_a.reg_write, bus_a.alu_src_a, bus_a.shift_src, bus_a.zero_extend,
                    bus_a.alu_src_b, bus_a.pc_source, bus_a.alu_sel,
                    bus_a.instr_done, bus_a.illegal_op, bus_a.bus_error};
    assign act_b = {bus_b.pc_write, bus_b.pc_write_cond, bus_b.ir_write, bus_b.i_or_d,
                    bus_b.mem_read, bus_b.mem_write, bus_b.mem_to_reg, bus_b.reg_dst,
                    bus_b.reg_write, bus_b.alu_src_a, bus_b.shift_src, bus_b.zero_extend,
                    bus_b.alu_src_b, bus_b.pc_source, bus_b.alu_sel,
                    bus_b.instr_done, bus_b.illegal_op, bus_b.bus_error};

    int n_checks = 0;
    int n_fail = 0;
    int unsigned model_cnt = 0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_func = 6'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                          6'b101010, 6'b000000}) ? K_R : K_ILL;
            6'b000010: return K_J;
            6'b000100: return K_BEQ;
            6'b001000, 6'b001010, 6'b001100, 6'b001101: return K_I;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return A_SUB;
            6'b100100: return A_AND;
            6'b100101: return A_OR;
            6'b101010: return A_SLT;
            6'b000000: return A_SLL;
            default:   return A_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'b001010: return A_SLT;
            6'b001100: return A_AND;
            6'b001101: return A_OR;
            default:   return A_ADD;
        endcase
    endfunction

    // One clock cycle: apply inputs after the falling edge, then compare both DUTs
    task automatic cyc(input string tag, input logic rdy, input outs_t e);
        @(negedge clk);
        bus_a.op_code   = cur_op;
        bus_a.func_code = cur_func;
        bus_a.mem_ready = rdy;
        #1;
        check_eq({tag, "_outs"}, 32'(act_a), 32'(e));
        check_eq({tag, "_outs_w2"}, 32'(act_b), 32'(e));
        check_eq("retire_count", 32'(bus_a.retire_count), model_cnt & 32'hffff);
        check_eq("retire_count_w2", 32'(bus_b.retire_count), model_cnt & 32'h3);
        if (e.instr_done) model_cnt++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus_a.mem_ready = 1'($urandom);
        @(negedge clk);
        #1;
        check_eq("reset_outs", 32'(act_a), 32'd0);
        check_eq("reset_outs_w2", 32'(act_b), 32'd0);
        check_eq("reset_count", 32'(bus_a.retire_count), 32'd0);
        check_eq("reset_count_w2", 32'(bus_b.retire_count), 32'd0);
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    // Expected cycle sequence of one instruction; wf/wm are wait cycles in fetch and memory phases
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        outs_t e;
        kind_t k;
        cur_op = op;
        cur_func = fn;
        k = classify(op, fn);
        for (int i = 0; i < wf && i <= WAIT_MAX; i++) begin
            e = '0; e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_sel = A_ADD;
            e.bus_error = (i == WAIT_MAX);
            cyc("fetch_wait", 1'b0, e);
        end
        if (wf > WAIT_MAX) return;
        e = '0; e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_sel = A_ADD;
        e.ir_write = 1; e.pc_write = 1;
        cyc("fetch", 1'b1, e);
        e = '0; e.alu_src_b = 2'd3; e.alu_sel = A_ADD; e.illegal_op = (k == K_ILL);
        cyc("decode", 1'($urandom), e);
        case (k)
            K_R: begin
                e = '0; e.alu_src_a = 1; e.alu_sel = r_alu(fn); e.shift_src = (fn == 6'b000000);
                cyc("exec_r", 1'($urandom), e);
                e = '0; e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
                cyc("wb_alu_r", 1'($urandom), e);
            end
            K_I: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_sel = i_alu(op);
                e.zero_extend = (op == 6'b001100) || (op == 6'b001101);
                cyc("exec_i", 1'($urandom), e);
                e = '0; e.reg_write = 1; e.instr_done = 1;
                cyc("wb_alu_i", 1'($urandom), e);
            end
            K_LW, K_SW: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_sel = A_ADD;
                cyc("addr", 1'($urandom), e);
                for (int i = 0; i < wm && i <= WAIT_MAX; i++) begin
                    e = '0; e.i_or_d = 1; e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                    e.bus_error = (i == WAIT_MAX);
                    cyc("mem_wait", 1'b0, e);
                end
                if (wm > WAIT_MAX) return;
                e = '0; e.i_or_d = 1; e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                e.instr_done = (k == K_SW);
                cyc("mem", 1'b1, e);
                if (k == K_LW) begin
                    e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
                    cyc("wb_mem", 1'($urandom), e);
                end
            end
            K_BEQ: begin
                e = '0; e.alu_src_a = 1; e.alu_sel = A_SUB; e.pc_write_cond = 1;
                e.pc_source = 2'd1; e.instr_done = 1;
                cyc("branch", 1'($urandom), e);
            end
            K_J: begin
                e = '0; e.pc_write = 1; e.pc_source = 2'd2; e.instr_done = 1;
                cyc("jump", 1'($urandom), e);
            end
            default: ;
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom % 11)
            0, 1:    return 6'b000000;
            2:       return 6'b000010;
            3:       return 6'b000100;
            4:       return 6'b001000;
            5:       return 6'b001010;
            6:       return 6'b001100;
            7:       return 6'b001101;
            8:       return 6'b100011;
            9:       return 6'b101011;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_func();
        case ($urandom % 7)
            0:       return 6'b100000;
            1:       return 6'b100010;
            2:       return 6'b100100;
            3:       return 6'b100101;
            4:       return 6'b101010;
            5:       return 6'b000000;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom % 10);
        if (r < 5) return 0;
        if (r < 8) return int'($urandom % 4);
        if (r < 9) return WAIT_MAX;
        return WAIT_MAX + 1;
    endfunction

    initial begin
        bus_a.op_code = '0;
        bus_a.func_code = '0;
        bus_a.mem_ready = 1'b0;
        reset_dut();
        run_instr(6'b000000, 6'b100000, 0, 0);
        run_instr(6'b100011, 6'b000000, 0, 3);
        run_instr(6'b000000, 6'b100000, WAIT_MAX + 1, 0);
        run_instr(6'b111111, 6'b000000, 0, 0);
        run_instr(6'b000100, 6'b000000, 0, 0);
        run_instr(6'b000010, 6'b000000, 0, 0);
        run_instr(6'b000000, 6'b000000, 1, 0);
        run_instr(6'b000000, 6'b000001, 0, 0);
        run_instr(6'b001100, 6'b111111, WAIT_MAX, 0);
        run_instr(6'b101011, 6'b000000, 0, WAIT_MAX);
        run_instr(6'b101011, 6'b000000, 0, WAIT_MAX + 1);
        run_instr(6'b100011, 6'b000000, 2, WAIT_MAX + 1);
        reset_dut();
        for (int i = 0; i < 5; i++) run_instr(6'b000010, 6'b000000, 0, 0);
        begin
            outs_t e;
            cur_op = 6'b000010;
            e = '0; e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_sel = A_ADD;
            e.ir_write = 1; e.pc_write = 1;
            cyc("fetch_pre_reset", 1'b1, e);
        end
        reset_dut();
        run_instr(6'b000010, 6'b000000, 0, 0);
        for (int i = 0; i < 300; i++) run_instr(pick_op(), pick_func(), pick_wait(), pick_wait());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
